imem_loader: RTL and testbench

Boot-time controller for the instruction memory. It owns the imem port while a program image streams in over a byte interface and holds the core in reset-like stall until the image is complete and verified. It assembles little-endian 32-bit words and writes them from the fetch reset vector upward. After the load, it hands the read port to the fetch stage unchanged.

---
 rtl/imem_loader.sv | 132 +++++++++++++
 tb/tb_imem_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader for the instruction memory: streams a length-prefixed, XOR-checked
// image into imem from the reset vector upward, then hands the port to fetch.
module imem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter int unsigned BASE_WORD  = 32'h10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    input  logic                  i_reload,
    input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
    input  logic                  i_fetch_read,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_read,
    output logic                  o_mem_we,
    output logic [31:0]           o_mem_wdata,
    output logic                  o_core_hold,
    output logic                  o_load_done,
    output logic                  o_load_error
);
    localparam logic [ADDR_WIDTH-1:0] LP_BASE = ADDR_WIDTH'(BASE_WORD);

    typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CSUM, S_RUN, S_ERROR} state_t;

    state_t                  r_state, w_state_nxt;
    logic [15:0]             r_len, r_word_idx;
    logic [7:0]              r_csum;
    logic [1:0]              r_byte_idx;
    logic [23:0]             r_asm;
    logic                    r_we, r_done;
    logic [31:0]             r_wdata;
    logic [ADDR_WIDTH-1:0]   r_waddr;

    logic                    w_accept;
    logic [15:0]             w_word_inc;
    logic [ADDR_WIDTH-1:0]   w_wr_addr;

    assign w_accept   = i_rx_valid && o_rx_ready;
    assign w_word_inc = r_word_idx + 16'd1;
    // Modulo-2^ADDR_WIDTH: oversized images overwrite from the wrap point.
    assign w_wr_addr  = LP_BASE + ADDR_WIDTH'(r_word_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_LEN0;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_rx_ready   = 1'b0;
        o_core_hold  = 1'b1;
        o_mem_read   = 1'b0;
        o_load_error = 1'b0;
        // The pending write keeps its own address; word_idx has already advanced.
        o_mem_addr   = r_we ? r_waddr : w_wr_addr;
        case (r_state)
            S_LEN0: begin
                o_rx_ready = 1'b1;
                if (w_accept) w_state_nxt = S_LEN1;
            end
            S_LEN1: begin
                o_rx_ready = 1'b1;
                if (w_accept) w_state_nxt = ({i_rx_data, r_len[7:0]} != 16'd0) ? S_DATA : S_CSUM;
            end
            S_DATA: begin
                o_rx_ready = 1'b1;
                if (w_accept && r_byte_idx == 2'd3 && w_word_inc == r_len) w_state_nxt = S_CSUM;
            end
            S_CSUM: begin
                o_rx_ready = 1'b1;
                if (w_accept) w_state_nxt = (i_rx_data == r_csum) ? S_RUN : S_ERROR;
            end
            S_RUN: begin
                o_core_hold = 1'b0;
                o_mem_read  = i_fetch_read;
                o_mem_addr  = i_fetch_addr;
                if (i_reload) w_state_nxt = S_LEN0;
            end
            S_ERROR: begin
                o_load_error = 1'b1;
                if (i_reload) w_state_nxt = S_LEN0;
            end
            default: w_state_nxt = S_LEN0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_word_idx <= '0;
            r_csum     <= '0;
            r_byte_idx <= '0;
            r_asm      <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_waddr    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= (r_state != S_RUN) && (w_state_nxt == S_RUN);
            case (r_state)
                S_LEN0: if (w_accept) r_len[7:0]  <= i_rx_data;
                S_LEN1: if (w_accept) r_len[15:8] <= i_rx_data;
                S_DATA: if (w_accept) begin
                    r_csum     <= r_csum ^ i_rx_data;
                    r_byte_idx <= r_byte_idx + 2'd1;
                    if (r_byte_idx == 2'd3) begin
                        r_we       <= 1'b1;
                        r_wdata    <= {i_rx_data, r_asm};
                        r_waddr    <= w_wr_addr;
                        r_word_idx <= w_word_inc;
                    end else begin
                        r_asm[r_byte_idx*8 +: 8] <= i_rx_data;
                    end
                end
                S_RUN, S_ERROR: if (i_reload) begin
                    r_len      <= '0;
                    r_csum     <= '0;
                    r_byte_idx <= '0;
                    r_word_idx <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_mem_we    = r_we;
    assign o_mem_wdata = r_wdata;
    assign o_load_done = r_done;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: image loads, checksum error, wrap, pass-through,
// reload and asynchronous reset mid-load, with a write-capture memory model.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        reload = 1'b0;
    logic [7:0]  fetch_addr = '0;
    logic        fetch_read = 1'b0;
    logic [7:0]  mem_addr;
    logic        mem_read, mem_we, core_hold, load_done, load_error;
    logic [31:0] mem_wdata;

    int n_chk = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    logic [31:0] mdl [256];
    logic [7:0]  tb_csum;

    imem_loader #(.ADDR_WIDTH(8), .BASE_WORD(32'h10)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
        .i_reload(reload), .i_fetch_addr(fetch_addr), .i_fetch_read(fetch_read),
        .o_mem_addr(mem_addr), .o_mem_read(mem_read), .o_mem_we(mem_we),
        .o_mem_wdata(mem_wdata), .o_core_hold(core_hold),
        .o_load_done(load_done), .o_load_error(load_error)
    );

    always #5 clk = ~clk;

    // Each write lasts one cycle, so exactly one falling edge sees it.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_cnt <= wr_cnt + 1;
            mdl[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        check("rx_ready_on_send", {31'd0, rx_ready}, 32'd1);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            tb_csum ^= w[k*8 +: 8];
            send_byte(w[k*8 +: 8]);
        end
    endtask

    task automatic send_len(input logic [15:0] n);
        tb_csum = 8'h00;
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    initial begin
        int base_cnt;
        logic [31:0] w;

        // Reset state
        #12;
        check("rst_core_hold", {31'd0, core_hold}, 32'd1);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_load_error", {31'd0, load_error}, 32'd0);
        fetch_read = 1'b1;
        #1;
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'h10);
        fetch_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single word: 01 00 EF BE AD DE 22
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD);
        check("sw_we_before", {31'd0, mem_we}, 32'd0);
        send_byte(8'hDE);
        check("sw_we", {31'd0, mem_we}, 32'd1);
        check("sw_addr", {24'd0, mem_addr}, 32'h10);
        check("sw_data", mem_wdata, 32'hDEADBEEF);
        check("sw_hold_during_write", {31'd0, core_hold}, 32'd1);
        send_byte(8'h22);
        check("sw_done", {31'd0, load_done}, 32'd1);
        check("sw_hold", {31'd0, core_hold}, 32'd0);
        check("sw_err", {31'd0, load_error}, 32'd0);
        check("sw_we_after", {31'd0, mem_we}, 32'd0);
        check("sw_ready_run", {31'd0, rx_ready}, 32'd0);
        check("sw_wr_cnt", wr_cnt, 32'd1);
        @(posedge clk); #1;
        check("sw_done_pulse", {31'd0, load_done}, 32'd0);

        // Pass-through and reload
        fetch_addr = 8'h20; fetch_read = 1'b1;
        #1;
        check("pt_addr", {24'd0, mem_addr}, 32'h20);
        check("pt_read", {31'd0, mem_read}, 32'd1);
        do_reload();
        check("rl_hold", {31'd0, core_hold}, 32'd1);
        check("rl_read", {31'd0, mem_read}, 32'd0);
        check("rl_ready", {31'd0, rx_ready}, 32'd1);
        check("rl_addr", {24'd0, mem_addr}, 32'h10);
        fetch_read = 1'b0;

        // Zero length, good checksum
        base_cnt = wr_cnt;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("z_done", {31'd0, load_done}, 32'd1);
        check("z_hold", {31'd0, core_hold}, 32'd0);
        check("z_no_write", wr_cnt, base_cnt);
        do_reload();

        // Zero length, bad checksum -> ERROR; reload during load is ignored
        send_byte(8'h00);
        reload = 1'b1;
        send_byte(8'h00);
        reload = 1'b0;
        check("z_reload_ignored", {31'd0, rx_ready}, 32'd1);
        send_byte(8'h5A);
        check("e_err", {31'd0, load_error}, 32'd1);
        check("e_hold", {31'd0, core_hold}, 32'd1);
        check("e_ready", {31'd0, rx_ready}, 32'd0);
        check("e_done", {31'd0, load_done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("e_err_level", {31'd0, load_error}, 32'd1);
        do_reload();
        check("e_rl_err", {31'd0, load_error}, 32'd0);
        check("e_rl_ready", {31'd0, rx_ready}, 32'd1);

        // Back-to-back N=3
        base_cnt = wr_cnt;
        send_len(16'd3);
        send_word(32'h11223344);
        send_word(32'h55667788);
        send_word(32'h99AABBCC);
        send_byte(tb_csum);
        check("b2b_done", {31'd0, load_done}, 32'd1);
        check("b2b_cnt", wr_cnt - base_cnt, 32'd3);
        check("b2b_w0", mdl[8'h10], 32'h11223344);
        check("b2b_w1", mdl[8'h11], 32'h55667788);
        check("b2b_w2", mdl[8'h12], 32'h99AABBCC);
        do_reload();

        // Wrap: N=0xF1, word i lands at (0x10+i) mod 256
        base_cnt = wr_cnt;
        send_len(16'h00F1);
        for (int i = 0; i < 241; i++) begin
            w = {8'(i), 8'(~i), 8'hC3, 8'(i ^ 8'h5A)};
            send_word(w);
        end
        send_byte(tb_csum);
        check("wrap_done", {31'd0, load_done}, 32'd1);
        check("wrap_cnt", wr_cnt - base_cnt, 32'd241);
        check("wrap_w240_at_00", mdl[8'h00], {8'd240, 8'h0F, 8'hC3, 8'hAA});
        check("wrap_w239_at_ff", mdl[8'hFF], {8'd239, 8'h10, 8'hC3, 8'hB5});
        check("wrap_w0_at_10", mdl[8'h10], {8'd0, 8'hFF, 8'hC3, 8'h5A});
        do_reload();

        // Async reset between bytes 2 and 3 of a word
        base_cnt = wr_cnt;
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_hold", {31'd0, core_hold}, 32'd1);
        check("ar_ready", {31'd0, rx_ready}, 32'd1);
        check("ar_we", {31'd0, mem_we}, 32'd0);
        check("ar_wdata", mem_wdata, 32'd0);
        check("ar_addr", {24'd0, mem_addr}, 32'h10);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ar_no_write", wr_cnt, base_cnt);

        // Full image after reset: 01 00 78 56 34 12 08
        send_len(16'd1);
        send_word(32'h12345678);
        check("ar_csum_model", {24'd0, tb_csum}, 32'h08);
        send_byte(8'h08);
        check("ar_done", {31'd0, load_done}, 32'd1);
        check("ar_word", mdl[8'h10], 32'h12345678);
        check("ar_cnt", wr_cnt - base_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
